mdu_unit: RTL

//  Execute-stage multiply/divide unit. It owns the HI/LO registers and runs mult/multu/div/divu/msub
//  as multi-cycle operations. It drives the Busy flag that the hazard unit ORs with the E-stage Start

---
 rtl/mdu_if.sv | 22 ++
 rtl/mdu_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mdu_if.sv
// Execute-stage multiply/divide unit bus: op request from E stage, busy/HI/LO back out.
interface mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic        mdu_clr;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output start, mdu_op, mdu_clr, src_a, src_b, rd_sel,
        input  busy, rd_data, hi_q, lo_q
    );
    modport slave (
        input  start, mdu_op, mdu_clr, src_a, src_b, rd_sel,
        output busy, rd_data, hi_q, lo_q
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle mult/multu/div/divu/msub with HI/LO ownership. The result is computed at accept
// and held pending until the latency counter expires, so HI/LO only ever show committed values.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    phi_q, phi_d, plo_q, plo_d;
    logic           pwr_q, pwr_d;

    logic [31:0] a, b;
    logic        long_op, is_div, div_zero;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] ua, ub, uq, ur, sq, sr;

    assign a = bus.src_a;
    assign b = bus.src_b;

    assign is_div   = (bus.mdu_op == OP_DIV) || (bus.mdu_op == OP_DIVU);
    assign long_op  = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) || is_div ||
                      (bus.mdu_op == OP_MSUB);
    assign div_zero = (b == 32'd0);

    // Signed divide done on magnitudes so the 0x80000000 / -1 case wraps to 0x80000000 cleanly.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};
        ua     = a[31] ? -a : a;
        ub     = b[31] ? -b : b;
        uq     = div_zero ? 32'd0 : ua / ub;
        ur     = div_zero ? 32'd0 : ua % ub;
        sq     = (a[31] ^ b[31]) ? -uq : uq;
        sr     = a[31] ? -ur : ur;
        case (bus.mdu_op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {sr, sq};
            OP_DIVU:  res = div_zero ? 64'd0 : {a % b, a / b};
            OP_MSUB:  res = {hi_q, lo_q} - prod_s;
            default:  res = 64'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            IDLE: begin
                if (!bus.mdu_clr) begin
                    if (bus.start && long_op) begin
                        state_d        = RUN;
                        count_d        = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        {phi_d, plo_d} = res;
                        pwr_d          = !(is_div && div_zero);
                    end else if (bus.mdu_op == OP_MTHI) begin
                        hi_d = a;
                    end else if (bus.mdu_op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.hi_q    = hi_q;
    assign bus.lo_q    = lo_q;
    assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;
endmodule
